adder_accumulator: RTL and testbench
====================================

ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 8, giving the accumulator width in bits (legal range 4..16).
REQ-002 The block SHALL have parameter BURST_LEN, default 4, giving the number of adder results per burst (legal range 1..7).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port sum, input, 2, the sum bits from the upstream 2-bit ripple carry adder.
REQ-006 The block SHALL have port c_out, input, 1, the carry out from the upstream adder.
REQ-007 The block SHALL have port in_valid, input, 1, meaning sum and c_out hold a result to consume.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts a result this cycle.
REQ-009 The block SHALL have port clear, input, 1, a synchronous abort of the current burst.
REQ-010 The block SHALL have port out_valid, output, 1, meaning acc_out and overflow hold a completed burst total.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes the total this cycle.
REQ-012 The block SHALL have port acc_out, output, ACC_W, the burst total.
REQ-013 The block SHALL have port overflow, output, 1, meaning the burst total wrapped past 2^ACC_W-1.
REQ-014 The block SHALL have port count, output, 3, the number of results accepted in the current burst.

Function
REQ-015 A result SHALL be accepted only in a cycle where in_valid and in_ready are both 1; its value is {c_out,sum} zero-extended to ACC_W (range 0..7).
REQ-016 The FSM SHALL have states IDLE, ACCUM and HOLD; in_ready is 1 in IDLE and ACCUM and 0 in HOLD; out_valid is 1 only in HOLD.
REQ-017 In IDLE, an accepted result SHALL load acc with the value and set count to 1; next state is HOLD if BURST_LEN==1, else ACCUM.
REQ-018 In ACCUM, an accepted result SHALL set acc to acc+value modulo 2^ACC_W and increment count; when count reaches BURST_LEN the next state is HOLD.
REQ-019 In IDLE or ACCUM with no accepted result, acc, count and state SHALL hold (gaps in in_valid are legal).
REQ-020 overflow SHALL be set on any accumulation whose true sum exceeds 2^ACC_W-1, remain set for the rest of the burst, and be cleared when a new burst loads in IDLE.
REQ-021 out_valid SHALL rise the cycle after the BURST_LEN-th result is accepted (latency 1 cycle).
REQ-022 In HOLD, acc_out, overflow and count SHALL stay stable until out_ready is sampled 1; then the next state is IDLE and out_valid drops the following cycle.
REQ-023 A result presented with in_valid=1 while in HOLD SHALL NOT be accepted, including the cycle out_ready=1; it is accepted in IDLE the next cycle if still valid.
REQ-024 clear=1 SHALL have priority over all other inputs in every state: next state IDLE, acc=0, count=0, overflow=0, and no result accepted that cycle.
REQ-025 acc_out SHALL continuously reflect the acc register in every state.

Reset
REQ-026 On rst=1, asynchronously and regardless of clk: state=IDLE, acc_out=0, count=0, overflow=0, out_valid=0, in_ready=1 (in_ready combinational from IDLE).
REQ-027 Reset asserted mid-burst or in HOLD SHALL discard the partial or pending total with no out_valid pulse; operation resumes in IDLE on the first clk edge after rst falls.

Verification
REQ-028 Defaults, results {c_out,sum} = 5,7,3,3 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th, acc_out=0x12, overflow=0, count=4, out_valid high exactly 1 cycle.
REQ-029 ACC_W=4, same four results -> acc_out=0x2, overflow=1 (wrap on the 4th result at 15+3).
REQ-030 Defaults, four results of 7 with out_ready=0 for 5 cycles then 1 -> acc_out=0x1C held stable, in_ready=0 for the whole hold, a 5th valid result is taken only after return to IDLE.
REQ-031 Defaults, results 5 and 7 separated by 3-cycle in_valid gaps, then clear=1 with in_valid=1 -> count=0, acc_out=0, result not accepted; the next 4 results form a clean burst.
REQ-032 rst pulsed between clk edges after 2 accepted results -> outputs zero immediately, no out_valid pulse; the next burst of 5,7,3,3 gives 0x12.

Source files
------------

// File: rtl/adder_accumulator.sv
// Accumulates bursts of BURST_LEN 3-bit results ({c_out,sum}) from an upstream
// 2-bit ripple carry adder. When a burst completes, the block presents the total
// with a valid/ready handshake. The overflow flag is sticky within a burst.
module adder_accumulator #(
    parameter int unsigned ACC_W     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sum,
    input  logic             c_out,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic [2:0]       count
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic [2:0] BurstLen = 3'(BURST_LEN);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [2:0]       count_q;

    logic [ACC_W-1:0] value;
    logic [ACC_W:0]   acc_sum;
    logic             accept;
    logic [2:0]       count_inc;

    // Decode the incoming result, the widened running sum and the handshake.
    always_comb begin
        value     = {{(ACC_W-3){1'b0}}, c_out, sum};
        acc_sum   = {1'b0, acc_q} + {1'b0, value};
        in_ready  = (state_q != StHold);
        out_valid = (state_q == StHold);
        accept    = in_valid && in_ready && !clear;
        count_inc = count_q + 3'd1;
    end

    // Single FSM with the accumulator, the sticky overflow flag and the result counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else if (clear) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        acc_q   <= value;
                        ovf_q   <= 1'b0;
                        count_q <= 3'd1;
                        state_q <= (BurstLen == 3'd1) ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        acc_q   <= acc_sum[ACC_W-1:0];
                        ovf_q   <= ovf_q | acc_sum[ACC_W];
                        count_q <= count_inc;
                        if (count_inc == BurstLen) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    // Total stays frozen until the consumer takes it.
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs follow the registers directly.
    always_comb begin
        acc_out  = acc_q;
        overflow = ovf_q;
        count    = count_q;
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator. Two instances, one with ACC_W=8 and one with
// ACC_W=4, receive the same stimulus. A burst-level model tracks the true
// integer total of the current burst. Both widths are derived from that total
// by taking it modulo 2^W.
module tb_adder_accumulator;

    localparam int unsigned BL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sum;
    logic       c_out;
    logic       in_valid;
    logic       clear;
    logic       out_ready;

    logic       in_ready8, out_valid8, overflow8;
    logic [7:0] acc_out8;
    logic [2:0] count8;
    logic       in_ready4, out_valid4, overflow4;
    logic [3:0] acc_out4;
    logic [2:0] count4;

    int checks = 0;
    int errors = 0;
    int ov_pulses = 0;

    // Model state: results taken in the current burst, their true sum, and the holding flag.
    int m_n   = 0;
    int m_tot = 0;
    bit m_hold = 1'b0;

    always #5 clk = ~clk;

    adder_accumulator #(.ACC_W(8), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .sum(sum), .c_out(c_out), .in_valid(in_valid),
        .in_ready(in_ready8), .clear(clear), .out_valid(out_valid8), .out_ready(out_ready),
        .acc_out(acc_out8), .overflow(overflow8), .count(count8)
    );

    adder_accumulator #(.ACC_W(4), .BURST_LEN(BL)) dut4 (
        .clk(clk), .rst(rst), .sum(sum), .c_out(c_out), .in_valid(in_valid),
        .in_ready(in_ready4), .clear(clear), .out_valid(out_valid4), .out_ready(out_ready),
        .acc_out(acc_out4), .overflow(overflow4), .count(count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_tot  = 0;
        m_hold = 1'b0;
    endtask

    always @(posedge rst) model_reset();

    // Advance the model on each edge, then compare every output just after it.
    always @(posedge clk) begin
        if (rst || clear) begin
            model_reset();
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            if (m_n == 0 || m_n == BL) begin
                m_tot = int'({c_out, sum});
                m_n   = 1;
            end else begin
                m_tot += int'({c_out, sum});
                m_n++;
            end
            if (m_n == BL) m_hold = 1'b1;
        end
        #1;
        check("in_ready8", 32'(in_ready8), 32'(!m_hold));
        check("out_valid8", 32'(out_valid8), 32'(m_hold));
        check("count8", 32'(count8), 32'(m_n));
        check("acc_out8", 32'(acc_out8), 32'(m_tot % 256));
        check("overflow8", 32'(overflow8), 32'(m_tot >= 256));
        check("in_ready4", 32'(in_ready4), 32'(!m_hold));
        check("out_valid4", 32'(out_valid4), 32'(m_hold));
        check("count4", 32'(count4), 32'(m_n));
        check("acc_out4", 32'(acc_out4), 32'(m_tot % 16));
        check("overflow4", 32'(overflow4), 32'(m_tot >= 16));
        if (out_valid8) ov_pulses++;
    end

    // Drive one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic cyc(input logic iv, input int val, input logic cl, input logic ordy);
        in_valid  = iv;
        {c_out, sum} = 3'(val);
        clear     = cl;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sum = 2'd0; c_out = 1'b0; clear = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_acc", 32'(acc_out8), 32'h0);
        check("rst_in_ready", 32'(in_ready8), 32'h1);
        check("rst_out_valid", 32'(out_valid8), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Defaults: 5,7,3,3 -> 0x12; the 4-bit instance wraps at 15+3.
        ov_pulses = 0;
        cyc(1, 5, 0, 1); cyc(1, 7, 0, 1); cyc(1, 3, 0, 1); cyc(1, 3, 0, 1);
        check("b1_out_valid", 32'(out_valid8), 32'h1);
        check("b1_acc8", 32'(acc_out8), 32'h12);
        check("b1_ovf8", 32'(overflow8), 32'h0);
        check("b1_count", 32'(count8), 32'd4);
        check("b1_acc4", 32'(acc_out4), 32'h2);
        check("b1_ovf4", 32'(overflow4), 32'h1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        check("b1_pulse_len", 32'(ov_pulses), 32'd1);

        // Four 7s with the consumer stalled for 5 cycles while a 5th result waits.
        cyc(1, 7, 0, 0); cyc(1, 7, 0, 0); cyc(1, 7, 0, 0); cyc(1, 7, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("hold_acc", 32'(acc_out8), 32'h1C);
            check("hold_in_ready", 32'(in_ready8), 32'h0);
            cyc(1, 7, 0, 0);
        end
        check("hold_count", 32'(count8), 32'd4);
        cyc(1, 7, 0, 1);
        check("release_in_ready", 32'(in_ready8), 32'h1);
        check("release_acc4", 32'(acc_out4), 32'hC);
        cyc(1, 7, 0, 0);
        check("fifth_count", 32'(count8), 32'd1);
        check("fifth_acc", 32'(acc_out8), 32'h7);
        cyc(1, 7, 0, 0); cyc(1, 7, 0, 0); cyc(1, 7, 0, 0);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // Gapped results then a clear with a valid result present.
        cyc(1, 5, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        check("gap_count", 32'(count8), 32'd1);
        cyc(1, 7, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        check("gap_acc", 32'(acc_out8), 32'd12);
        cyc(1, 3, 1, 1);
        check("clear_count", 32'(count8), 32'd0);
        check("clear_acc", 32'(acc_out8), 32'd0);
        check("clear_in_ready", 32'(in_ready8), 32'h1);
        cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1); cyc(1, 4, 0, 1);
        check("clean_acc8", 32'(acc_out8), 32'd10);
        check("clean_acc4", 32'(acc_out4), 32'd10);
        check("clean_ovf4", 32'(overflow4), 32'h0);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // Reset pulse between edges after two accepted results.
        ov_pulses = 0;
        cyc(1, 5, 0, 1); cyc(1, 7, 0, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_acc", 32'(acc_out8), 32'd0);
        check("arst_count", 32'(count8), 32'd0);
        check("arst_in_ready", 32'(in_ready8), 32'h1);
        #1 rst = 1'b0;
        @(negedge clk);
        check("arst_no_pulse", 32'(ov_pulses), 32'd0);
        cyc(1, 5, 0, 1); cyc(1, 7, 0, 1); cyc(1, 3, 0, 1); cyc(1, 3, 0, 1);
        check("post_rst_acc", 32'(acc_out8), 32'h12);
        check("post_rst_valid", 32'(out_valid8), 32'h1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
